// File: rtl/player2_position.sv
// Player 2 X-position integrator, stepped once per synchronized frame tick.
// In: clk, Reset_n, frame_clk, walk keys, knockback step, P1 X. Out: Xpos, Moving, Knocked.
module player2_position #(
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 638,
  parameter int SPRITE_W  = 125,
  parameter int X_START   = 450,
  parameter int WALK_STEP = 2
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic               Walk_Left,
  input  logic               Walk_Right,
  input  logic signed [31:0] Knock_Motion,
  input  logic signed [31:0] Opp_Xpos,
  output logic signed [31:0] Xpos,
  output logic               Moving,
  output logic               Knocked
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WALK_L = 2'd1;
  localparam logic [1:0] WALK_R = 2'd2;
  localparam logic [1:0] KNOCK  = 2'd3;

  localparam logic signed [31:0] HI = X_MAX - SPRITE_W;
  localparam logic signed [31:0] LO_MIN = X_MIN;
  localparam logic signed [31:0] STEP = WALK_STEP;
  localparam logic signed [31:0] START = X_START;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       sync1;
  logic       sync2;
  logic       sync3;
  logic       tick;

  logic signed [31:0] delta;
  logic signed [31:0] sum;
  logic signed [31:0] lo_raw;
  logic signed [31:0] lo;
  logic signed [31:0] after_lo;
  logic signed [31:0] nxt;

  logic knock_req;
  logic left_req;
  logic right_req;

  // Flops reset high so a frame_clk already high at release is not an edge.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= frame_clk;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign tick = sync2 & ~sync3;

  assign knock_req = (Knock_Motion != 32'sd0);
  assign left_req  = ~knock_req & Walk_Left & ~Walk_Right;
  assign right_req = ~knock_req & Walk_Right & ~Walk_Left;

  always_comb begin
    state_nxt = IDLE;
    delta     = 32'sd0;
    unique case (1'b1)
      knock_req: begin
        state_nxt = KNOCK;
        delta     = Knock_Motion;
      end
      left_req: begin
        state_nxt = WALK_L;
        delta     = -STEP;
      end
      right_req: begin
        state_nxt = WALK_R;
        delta     = STEP;
      end
      default: begin
        state_nxt = IDLE;
        delta     = 32'sd0;
      end
    endcase
  end

  // Leftward motion stops at the opponent's right edge; an existing
  // overlap is held rather than resolved by pulling toward P1.
  always_comb begin
    sum      = Xpos + delta;
    lo_raw   = Opp_Xpos + SPRITE_W;
    lo       = (lo_raw > LO_MIN) ? lo_raw : LO_MIN;
    after_lo = sum;
    if ((delta < 32'sd0) && (sum < lo)) begin
      after_lo = (Xpos >= lo) ? lo : Xpos;
    end
    nxt = (after_lo > HI) ? HI : after_lo;
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Xpos  <= START;
      state <= IDLE;
    end else if (tick) begin
      Xpos  <= nxt;
      state <= state_nxt;
    end
  end

  assign Moving  = (state == WALK_L) | (state == WALK_R);
  assign Knocked = (state == KNOCK);

endmodule

// File: tb/tb_player2_position.sv
// Randomized and directed bench for player2_position.
// Reference model computes each frame's result from the movement rules.
module tb_player2_position;

  logic        clk;
  logic        Reset_n;
  logic        frame_clk;
  logic        Walk_Left;
  logic        Walk_Right;
  logic signed [31:0] Knock_Motion;
  logic signed [31:0] Opp_Xpos;
  logic signed [31:0] Xpos;
  logic        Moving;
  logic        Knocked;

  int total;
  int bad;

  // model state: x position and category (0 idle, 1 left, 2 right, 3 knock)
  int mx;
  int mst;

  player2_position dut (
    .clk          (clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .Walk_Left    (Walk_Left),
    .Walk_Right   (Walk_Right),
    .Knock_Motion (Knock_Motion),
    .Opp_Xpos     (Opp_Xpos),
    .Xpos         (Xpos),
    .Moving       (Moving),
    .Knocked      (Knocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int x, input int km,
                                input bit wl, input bit wr,
                                input int opp,
                                output int nx, output int st);
    longint d;
    longint n;
    longint lo;
    if (km != 0) begin
      d = km; st = 3;
    end else if (wl && !wr) begin
      d = -2; st = 1;
    end else if (wr && !wl) begin
      d = 2; st = 2;
    end else begin
      d = 0; st = 0;
    end
    n = x + d;
    if (d < 0) begin
      lo = opp + 125;
      if (lo < 0) lo = 0;
      if (n < lo) n = (x >= lo) ? lo : x;
    end
    if (n > 513) n = 513;
    nx = int'(n);
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_x"}, Xpos, mx);
    check({tag, "_mv"}, int'(Moving), int'(mst == 1 || mst == 2));
    check({tag, "_kn"}, int'(Knocked), int'(mst == 3));
  endtask

  task automatic do_frame(input int km, input bit wl, input bit wr,
                          input int opp);
    int nx;
    int nst;
    @(negedge clk);
    Knock_Motion = km;
    Walk_Left    = wl;
    Walk_Right   = wr;
    Opp_Xpos     = opp;
    model(mx, km, wl, wr, opp, nx, nst);
    @(negedge clk);
    frame_clk = 1'b1;
    @(posedge clk); #1;
    check("edge1", Xpos, mx);
    @(posedge clk); #1;
    check_state("edge2");
    @(posedge clk); #1;
    mx  = nx;
    mst = nst;
    check_state("edge3");
    // knockback changes between ticks must not matter
    Knock_Motion = int'($urandom_range(80, 0)) - 40;
    repeat (3) @(posedge clk);
    #1;
    check_state("hold");
    @(negedge clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    check_state("low");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    Reset_n = 1'b0;
    #1;
    mx  = 450;
    mst = 0;
    check_state("rst");
    #1;
    Reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_state("rst_rel");
  endtask

  initial begin
    int opp;
    total        = 0;
    bad          = 0;
    Reset_n      = 1'b0;
    frame_clk    = 1'b0;
    Walk_Left    = 1'b0;
    Walk_Right   = 1'b0;
    Knock_Motion = 0;
    Opp_Xpos     = 0;
    mx           = 450;
    mst          = 0;

    // reset held while frame_clk toggles
    for (int i = 0; i < 4; i++) begin
      repeat (2) @(negedge clk);
      frame_clk = ~frame_clk;
      Walk_Right = 1'b1;
      check_state("in_rst");
    end
    @(negedge clk);
    frame_clk = 1'b1;
    #2;
    Reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_state("rel_high");
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);

    // walk right three frames
    for (int i = 0; i < 3; i++) do_frame(0, 1'b0, 1'b1, 0);
    check("walk_r_456", Xpos, 456);

    // walk up to 510, then knockback against the right wall
    for (int i = 0; i < 27; i++) do_frame(0, 1'b0, 1'b1, 0);
    check("at_510", Xpos, 510);
    do_frame(9, 1'b0, 1'b0, 0);
    check("wall_513", Xpos, 513);
    do_frame(8, 1'b0, 1'b0, 0);
    check("wall_hold", Xpos, 513);

    // left walk against the opponent
    do_frame(-67, 1'b0, 1'b0, 0);
    check("at_446", Xpos, 446);
    do_frame(0, 1'b1, 1'b0, 320);
    check("opp_445", Xpos, 445);
    do_frame(0, 1'b1, 1'b0, 320);
    check("opp_hold", Xpos, 445);

    // both keys idle, then knock overrides walk
    do_frame(0, 1'b1, 1'b1, 320);
    check("both_idle", Xpos, 445);
    do_frame(5, 1'b1, 1'b0, 320);
    check("knock_ovr", Xpos, 450);

    // reset mid-knock, next frame from idle
    do_frame(20, 1'b0, 1'b0, 0);
    pulse_reset();
    do_frame(0, 1'b0, 1'b1, 0);
    check("post_rst", Xpos, 452);

    // randomized frames
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(39, 0) == 0) pulse_reset();
      opp = int'($urandom_range(420, 0));
      if ($urandom_range(9, 0) < 3)
        do_frame(int'($urandom_range(120, 0)) - 60,
                 1'($urandom), 1'($urandom), opp);
      else
        do_frame(0, 1'($urandom), 1'($urandom), opp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
